zeta_table_gen: RTL and testbench

ZETA_TABLE_GEN -- requirements
Module: zeta_table_gen

---
 rtl/zeta_table_gen.sv | 142 ++++++++++++++
 tb/tb_zeta_table_gen.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/zeta_table_gen.sv
// -----------------------------------------------------------------------------
// zeta_table_gen
//   Generates a bit-reversed twiddle ("zeta") table of N = 2^K entries into an
//   internal RAM. The result is table[i] = ROOT^bitrev_K(i) mod Q. When the
//   mode latched at start is 1, each entry is instead stored as (Q - z) mod Q.
//   One entry is written per cycle. Reads have a registered 1-cycle latency.
//
// Ports
//   clk      : single clock, rising edge
//   rst      : synchronous active-high reset
//   start    : request generation (accepted in IDLE only)
//   inv      : mode, sampled together with an accepted start
//   busy     : high while generating (N cycles)
//   done     : one-cycle pulse when generation completes
//   ready    : table contents valid
//   rd_en    : read request (accepted only when ready=1)
//   rd_addr  : table index
//   rd_data  : zeta value, zero when rd_valid=0
//   rd_valid : rd_data is valid this cycle
// -----------------------------------------------------------------------------
module zeta_table_gen #(
  parameter int ROOT_OF_UNITY = 17,
  parameter int Q             = 3329,
  parameter int K             = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         inv,
  output logic         busy,
  output logic         done,
  output logic         ready,
  input  logic         rd_en,
  input  logic [K-1:0] rd_addr,
  output logic [15:0]  rd_data,
  output logic         rd_valid
);

  localparam int N = 1 << K;
  // Pre-reduce the root so the 16x16 product always fits in 32 bits.
  localparam logic [15:0] ROOT_M = 16'(ROOT_OF_UNITY % Q);
  localparam logic [15:0] Q16    = 16'(Q);
  localparam logic [31:0] Q32    = 32'(Q);

  typedef enum logic [1:0] {IDLE, GEN, FIN} state_t;

  state_t        state_reg, state_next;
  logic [K-1:0]  cnt_reg, cnt_next;
  logic [15:0]   pow_reg, pow_next;
  logic          mode_reg, mode_next;
  logic          ready_reg, ready_next;
  logic          rd_valid_reg;
  logic [15:0]   mem_q_reg;

  logic [15:0]   zeta_mem [N];
  logic          wr_en;
  logic [K-1:0]  wr_addr;
  logic [15:0]  wr_data;
  logic [31:0]  prod;
  logic [15:0]  pow_mul;

  // Write address is the bit-reversed counter.
  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_bitrev
      assign wr_addr[gi] = cnt_reg[K-1-gi];
    end
  endgenerate

  assign prod    = {16'd0, pow_reg} * {16'd0, ROOT_M};
  assign pow_mul = 16'(prod % Q32);
  // pow is always in [0, Q-1]; a zero power must stay zero when negated.
  assign wr_data = (mode_reg && (pow_reg != 16'd0)) ? (Q16 - pow_reg) : pow_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pow_next   = pow_reg;
    mode_next  = mode_reg;
    ready_next = ready_reg;
    wr_en      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = GEN;
          cnt_next   = '0;
          pow_next   = 16'd1;
          mode_next  = inv;
          ready_next = 1'b0;
        end
      end
      GEN: begin
        wr_en    = 1'b1;
        pow_next = pow_mul;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == {K{1'b1}}) begin
          state_next = FIN;
        end
      end
      FIN: begin
        ready_next = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      pow_reg      <= 16'd1;
      mode_reg     <= 1'b0;
      ready_reg    <= 1'b0;
      rd_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      pow_reg      <= pow_next;
      mode_reg     <= mode_next;
      ready_reg    <= ready_next;
      rd_valid_reg <= rd_en & ready_reg;
    end
  end

  // Table RAM: no reset, registered read. A read accepted in the same cycle
  // as start sees the old contents since writes only begin in GEN.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      zeta_mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      mem_q_reg <= zeta_mem[rd_addr];
    end
  end

  assign busy     = (state_reg == GEN);
  assign done     = (state_reg == FIN);
  assign ready    = ready_reg;
  assign rd_valid = rd_valid_reg;
  assign rd_data  = rd_valid_reg ? mem_q_reg : 16'd0;

endmodule

// File: tb/tb_zeta_table_gen.sv
// -----------------------------------------------------------------------------
// tb_zeta_table_gen
//   Scoreboard bench for zeta_table_gen. Reads push an expected response into
//   a queue; a monitor pops and compares one cycle later. Expected table values
//   come from a direct modular-exponentiation model. A second small instance
//   (K=2, Q=17, ROOT=4) is checked against its known table.
// -----------------------------------------------------------------------------
module tb_zeta_table_gen;

  localparam int K    = 7;
  localparam int N    = 1 << K;
  localparam int Q    = 3329;
  localparam int ROOT = 17;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         inv = 1'b0;
  logic         busy, done, ready;
  logic         rd_en = 1'b0;
  logic [K-1:0] rd_addr = '0;
  logic [15:0]  rd_data;
  logic         rd_valid;

  logic         s_start = 1'b0;
  logic         s_inv = 1'b0;
  logic         s_busy, s_done, s_ready;
  logic         s_rd_en = 1'b0;
  logic [1:0]   s_rd_addr = '0;
  logic [15:0]  s_rd_data;
  logic         s_rd_valid;

  always #5 clk = ~clk;

  zeta_table_gen #(.ROOT_OF_UNITY(ROOT), .Q(Q), .K(K)) dut (
    .clk(clk), .rst(rst), .start(start), .inv(inv),
    .busy(busy), .done(done), .ready(ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  zeta_table_gen #(.ROOT_OF_UNITY(4), .Q(17), .K(2)) dut_small (
    .clk(clk), .rst(rst), .start(s_start), .inv(s_inv),
    .busy(s_busy), .done(s_done), .ready(s_ready),
    .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .rd_valid(s_rd_valid)
  );

  typedef struct {
    logic        v;
    logic [15:0] d;
    int          a;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Current model of the DUT's visible table state.
  bit   model_ready = 1'b0;
  bit   model_inv   = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int bitrev(input int x, input int bits);
    int r = 0;
    for (int b = 0; b < bits; b++) if ((x >> b) & 1) r |= 1 << (bits - 1 - b);
    return r;
  endfunction

  // table[i] = root^bitrev(i) mod q, negated mod q in inverse mode.
  function automatic int ref_zeta(input int root, input int q, input int bits,
                                  input int idx, input bit neg);
    longint p = 1;
    int e = bitrev(idx, bits);
    for (int j = 0; j < e; j++) p = (p * root) % q;
    if (neg) p = (q - p) % q;
    return int'(p);
  endfunction

  // Drive a read for the next edge and record what it must return.
  task automatic issue_read(input int addr, input bit use_const, input int cval);
    exp_t e;
    rd_en   = 1'b1;
    rd_addr = K'(addr);
    e.a = addr;
    if (rst || !model_ready) begin
      e.v = 1'b0;
      e.d = 16'd0;
    end else begin
      e.v = 1'b1;
      e.d = use_const ? 16'(cval) : 16'(ref_zeta(ROOT, Q, K, addr, model_inv));
    end
    exp_q.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic read_seq(input int addr);
    issue_read(addr, 1'b0, 0);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic read_const(input int addr, input int val);
    issue_read(addr, 1'b1, val);
    tick();
    rd_en = 1'b0;
  endtask

  // Run a generation. abort_at >= 0 applies reset at that GEN cycle.
  task automatic gen(input bit inv_v, input int abort_at, input bit repulse,
                     input bit rd_with_start);
    start = 1'b1;
    inv   = inv_v;
    if (rd_with_start) issue_read($urandom_range(N - 1), 1'b0, 0);
    else rd_en = 1'b0;
    tick();
    start = 1'b0;
    rd_en = 1'b0;
    model_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk("busy_in_gen", busy, 1);
      chk("done_in_gen", done, 0);
      start = 1'b0;
      inv   = $urandom_range(1);
      if (i == abort_at) begin
        rst   = 1'b1;
        start = 1'b1;
        issue_read($urandom_range(N - 1), 1'b0, 0);
        tick();
        rst   = 1'b0;
        start = 1'b0;
        rd_en = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_ready", ready, 0);
        for (int c = 0; c < N + 4; c++) begin
          if (done || ready) chk("abort_no_done", {31'd0, done} + {31'd0, ready}, 0);
          if ((c % 16) == 0) issue_read($urandom_range(N - 1), 1'b0, 0);
          else rd_en = 1'b0;
          tick();
        end
        rd_en = 1'b0;
        chk("abort_ready_end", ready, 0);
        return;
      end
      if (repulse && i == 10) start = 1'b1;
      if ($urandom_range(3) == 0) issue_read($urandom_range(N - 1), 1'b0, 0);
      else rd_en = 1'b0;
      tick();
    end
    start = 1'b0;
    rd_en = 1'b0;
    // Cycle N+1 counted from the start cycle: done pulse.
    chk("fin_busy", busy, 0);
    chk("fin_done", done, 1);
    tick();
    model_ready = 1'b1;
    model_inv   = inv_v;
    chk("post_done", done, 0);
    chk("post_ready", ready, 1);
  endtask

  // Monitor: compare the response one cycle after each sampled read.
  initial begin
    exp_t e;
    logic issued;
    forever begin
      @(posedge clk);
      issued = rd_en;
      @(negedge clk);
      if (issued) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("rd_valid[%0d]", e.a), rd_valid, e.v);
          chk($sformatf("rd_data[%0d]", e.a), rd_data, e.d);
        end
      end else begin
        if (rd_valid || rd_data != 16'd0) begin
          chk("idle_valid", rd_valid, 0);
          chk("idle_data", rd_data, 0);
        end
      end
    end
  end

  int s_exp[4] = '{1, 16, 4, 13};
  int cyc;

  initial begin
    // Reset with a read pending: must be refused.
    tick();
    issue_read(3, 1'b0, 0);
    tick();
    rd_en = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    read_seq(5);

    // Forward table, reads during GEN.
    gen(1'b0, -1, 1'b0, 1'b0);
    read_const(0, 1);
    read_const(1, 1729);
    read_const(2, 2580);
    read_const(3, 3289);
    read_const(64, 17);
    issue_read(5, 1'b0, 0); tick();
    issue_read(6, 1'b0, 0); tick();
    issue_read(7, 1'b0, 0); tick();
    rd_en = 1'b0;
    for (int r = 0; r < 20; r++) begin
      if ($urandom_range(1)) issue_read($urandom_range(N - 1), 1'b0, 0);
      else rd_en = 1'b0;
      tick();
    end
    rd_en = 1'b0;

    // Inverse table; read in the start cycle returns old contents.
    gen(1'b1, -1, 1'b0, 1'b1);
    read_const(0, 3328);
    read_const(1, 1600);
    read_const(64, 3312);

    // Abort mid-generation, then full regeneration with start re-pulsed.
    gen(1'b0, 40, 1'b0, 1'b0);
    gen(1'b0, -1, 1'b1, 1'b0);
    for (int a = 0; a < N; a++) begin
      issue_read(a, 1'b0, 0);
      tick();
    end
    rd_en = 1'b0;

    // Small configuration.
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    cyc = 1;
    while (!s_done && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("small_done_cycle", cyc, 5);
    tick();
    chk("small_ready", s_ready, 1);
    for (int a = 0; a < 4; a++) begin
      s_rd_en   = 1'b1;
      s_rd_addr = 2'(a);
      tick();
      chk($sformatf("small_valid[%0d]", a), s_rd_valid, 1);
      chk($sformatf("small_data[%0d]", a), s_rd_data, s_exp[a]);
    end
    s_rd_en = 1'b0;

    tick();
    tick();
    chk("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
